i2c_adc_target: RTL and testbench

I2C target (responder) that emulates a PCF8591-style ADC/DAC device on the FPGA side of the bus. Serves the same address/control/read transaction sequence that the team's I2C ADC master issues: address write 0x90, control byte, repeated START, address read 0x91, data bytes, STOP. Sits between the open-drain pad logic and a local sample source. Used as an on-chip loopback target for bring-up and as a bench responder.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_line_sync.sv | 59 +++++
 rtl/i2c_adc_target.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_adc_target.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C definitions for the ADC master and target
package i2c_pkg;

  // PCF8591 base address: 0x90 write / 0x91 read on the wire
  localparam logic [6:0] DEV_ADDR_PCF8591 = 7'h48;

  // Bus level of the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  // True when the upper seven bits of an address byte select this device
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
    return addr_byte[7:1] == dev_addr;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge and START/STOP strobes
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history flop per line; reset to the idle-high bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_hist <= scl_now;
      sda_hist <= sda_now;
    end
  end

  // Registered strobes; sda_level is registered alongside so it lines up with scl_rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_level <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      sda_level <= sda_now;
      scl_rise  <= scl_now & ~scl_hist;
      scl_fall  <= ~scl_now & scl_hist;
      // SDA edges only count as START/STOP while SCL is stably high
      start_det <= scl_now & scl_hist & sda_hist & ~sda_now;
      stop_det  <= scl_now & scl_hist & ~sda_hist & sda_now;
    end
  end

endmodule

// File: rtl/i2c_adc_target.sv
// rtl/i2c_adc_target.sv - I2C target emulating a PCF8591-style ADC/DAC
module i2c_adc_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_PCF8591,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] ctrl_out,
  output logic       ctrl_valid,
  output logic [7:0] dac_out,
  output logic       dac_valid,
  output logic       busy
);

  logic       sda_bit;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shift_nxt;
  logic       last_bit;
  logic       rw;
  // ACK states: set once SDA is being held low; RD_ACK: master acknowledged
  logic       ack_on;
  // Control byte already taken in this transaction (cleared only by STOP)
  logic       ctrl_seen;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_level(sda_bit),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign shift_nxt = {shreg[6:0], sda_bit};
  assign last_bit  = (bit_cnt == 4'd7);

  // Protocol FSM; every output is registered and SDA only moves after an SCL fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      ctrl_seen  <= 1'b0;
      sda_oe     <= 1'b0;
      tx_req     <= 1'b0;
      ctrl_out   <= 8'h00;
      ctrl_valid <= 1'b0;
      dac_out    <= 8'h00;
      dac_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_req     <= 1'b0;
      ctrl_valid <= 1'b0;
      dac_valid  <= 1'b0;

      if (start_det) begin
        // START or repeated START: restart address phase, keep ctrl tracking
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        bit_cnt   <= 4'd0;
        sda_oe    <= 1'b0;
        ack_on    <= 1'b0;
        busy      <= 1'b0;
        ctrl_seen <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                if (addr_match(shift_nxt, DEV_ADDR)) begin
                  state  <= ST_ADDR_ACK;
                  rw     <= shift_nxt[0];
                  ack_on <= 1'b0;
                end else begin
                  // Not for us: stay off the bus until the next START/STOP
                  state <= ST_WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                // Fall after bit 8: pull SDA low for the 9th clock
                sda_oe <= ~ACK;
                ack_on <= 1'b1;
                busy   <= 1'b1;
              end else begin
                // Fall after the 9th clock: hand SDA over to the next byte
                ack_on  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  shreg  <= tx_data;
                  tx_req <= 1'b1;
                  sda_oe <= ~tx_data[7];
                  state  <= ST_RD_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= ST_WR_BYTE;
                end
              end
            end
          end

          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                state  <= ST_WR_ACK;
                ack_on <= 1'b0;
                if (!ctrl_seen) begin
                  ctrl_out   <= shift_nxt;
                  ctrl_valid <= 1'b1;
                  ctrl_seen  <= 1'b1;
                end else begin
                  dac_out   <= shift_nxt;
                  dac_valid <= 1'b1;
                end
              end
            end
          end

          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (last_bit) begin
                // 8th fall: release so the master can drive its ACK/NACK
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                ack_on  <= 1'b0;
                state   <= ST_RD_ACK;
              end else begin
                // Rotate so the next bit to send always sits in bit 7
                shreg   <= {shreg[6:0], shreg[7]};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_bit == NACK) begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end else begin
                ack_on <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              bit_cnt <= 4'd0;
              shreg   <= tx_data;
              tx_req  <= 1'b1;
              sda_oe  <= ~tx_data[7];
              state   <= ST_RD_BYTE;
            end
          end

          ST_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_adc_target.sv
// tb/tb_i2c_adc_target.sv - scoreboard bench for i2c_adc_target
module tb_i2c_adc_target;

  localparam int Q = 80;

  localparam int P_OE     = 0;
  localparam int P_TXREQ  = 1;
  localparam int P_CTRL   = 2;
  localparam int P_DAC    = 3;
  localparam int P_BUSY   = 4;
  localparam int P_CV     = 5;
  localparam int P_DV     = 6;
  localparam int P_MARK   = 7;
  localparam int P_NTX    = 8;
  localparam int P_NCTRL  = 9;
  localparam int P_NDAC   = 10;
  localparam int P_NOE    = 11;
  localparam int P_DRAIN  = 12;

  typedef struct {
    int kind;
    int expv;
  } probe_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] ctrl_out;
  logic       ctrl_valid;
  logic [7:0] dac_out;
  logic       dac_valid;
  logic       busy;

  probe_t     probes[$];
  logic       exp_ack[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_ctrl[$];
  logic [7:0] exp_dac[$];
  logic [7:0] tx_seq[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         obs_ack_seq = 0;
  int         obs_rd_seq = 0;
  logic       obs_ack;
  logic [7:0] obs_rd;
  int         ack_seen = 0;
  int         rd_seen = 0;
  int         ctrl_cnt = 0;
  int         dac_cnt = 0;
  int         txreq_cnt = 0;
  int         oe_cnt = 0;
  int         ctrl_base = 0;
  int         dac_base = 0;
  int         txreq_base = 0;
  int         oe_base = 0;
  logic       oe_prev = 1'b0;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_adc_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .ctrl_out  (ctrl_out),
    .ctrl_valid(ctrl_valid),
    .dac_out   (dac_out),
    .dac_valid (dac_valid),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops expectations as the DUT or the bus master presents results
  always @(negedge clk) begin
    logic [7:0] e8;
    logic       e1;
    probe_t     p;
    if (ctrl_valid) begin
      ctrl_cnt++;
      if (exp_ctrl.size() == 0) check("ctrl_valid_unexpected", 1, 0);
      else begin
        e8 = exp_ctrl.pop_front();
        check("ctrl_out", int'(ctrl_out), int'(e8));
      end
    end
    if (dac_valid) begin
      dac_cnt++;
      if (exp_dac.size() == 0) check("dac_valid_unexpected", 1, 0);
      else begin
        e8 = exp_dac.pop_front();
        check("dac_out", int'(dac_out), int'(e8));
      end
    end
    if (tx_req) begin
      txreq_cnt++;
      if (tx_seq.size() != 0) e8 = tx_seq.pop_front();
    end
    tx_data = (tx_seq.size() != 0) ? tx_seq[0] : 8'hFF;
    if (obs_ack_seq != ack_seen) begin
      ack_seen = obs_ack_seq;
      if (exp_ack.size() == 0) check("ack_unexpected", 1, 0);
      else begin
        e1 = exp_ack.pop_front();
        check("ack_bit", int'(obs_ack), int'(e1));
      end
    end
    if (obs_rd_seq != rd_seen) begin
      rd_seen = obs_rd_seq;
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e8 = exp_rd.pop_front();
        check("rd_byte", int'(obs_rd), int'(e8));
      end
    end
    if (rst_n && (sda_oe != oe_prev)) check("oe_change_scl_level", int'(scl_in), 0);
    oe_prev = sda_oe;
    if (sda_oe) oe_cnt++;
    while (probes.size() != 0) begin
      p = probes.pop_front();
      case (p.kind)
        P_OE:    check("sda_oe", int'(sda_oe), p.expv);
        P_TXREQ: check("tx_req", int'(tx_req), p.expv);
        P_CTRL:  check("ctrl_out_level", int'(ctrl_out), p.expv);
        P_DAC:   check("dac_out_level", int'(dac_out), p.expv);
        P_BUSY:  check("busy", int'(busy), p.expv);
        P_CV:    check("ctrl_valid", int'(ctrl_valid), p.expv);
        P_DV:    check("dac_valid", int'(dac_valid), p.expv);
        P_MARK: begin
          ctrl_base  = ctrl_cnt;
          dac_base   = dac_cnt;
          txreq_base = txreq_cnt;
          oe_base    = oe_cnt;
        end
        P_NTX:   check("tx_req_count", txreq_cnt - txreq_base, p.expv);
        P_NCTRL: check("ctrl_valid_count", ctrl_cnt - ctrl_base, p.expv);
        P_NDAC:  check("dac_valid_count", dac_cnt - dac_base, p.expv);
        P_NOE:   check("sda_oe_cycles", oe_cnt - oe_base, p.expv);
        default: begin
          check("left_ack", exp_ack.size(), 0);
          check("left_rd", exp_rd.size(), 0);
          check("left_ctrl", exp_ctrl.size(), 0);
          check("left_dac", exp_dac.size(), 0);
        end
      endcase
    end
  end

  task automatic probe(input int kind, input int expv);
    probe_t p;
    p.kind = kind;
    p.expv = expv;
    probes.push_back(p);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(2 * Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; #(Q);
    scl_m = 1'b1; #(Q);
    s = sda_in; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic eack);
    logic s;
    exp_ack.push_back(eack);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    obs_ack = s;
    obs_ack_seq++;
  endtask

  task automatic read_byte(input logic [7:0] eb, input logic mack);
    logic       s;
    logic [7:0] r;
    r = 8'h00;
    exp_rd.push_back(eb);
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      r = {r[6:0], s};
    end
    obs_rd = r;
    obs_rd_seq++;
    clock_bit(mack, s);
  endtask

  task automatic gap();
    repeat (20) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(posedge clk);
    probe(P_OE, 0); probe(P_TXREQ, 0); probe(P_CTRL, 0); probe(P_DAC, 0);
    probe(P_BUSY, 0); probe(P_CV, 0); probe(P_DV, 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    gap();

    // Control write 0x02
    probe(P_MARK, 0);
    i2c_start();
    write_byte(8'h90, 1'b0);
    probe(P_BUSY, 1);
    exp_ctrl.push_back(8'h02);
    write_byte(8'h02, 1'b0);
    i2c_stop();
    probe(P_BUSY, 0); probe(P_NCTRL, 1); probe(P_CTRL, 8'h02);
    gap();

    // Control write, repeated START, single read with NACK
    probe(P_MARK, 0);
    tx_seq.push_back(8'hA5);
    i2c_start();
    write_byte(8'h90, 1'b0);
    exp_ctrl.push_back(8'h02);
    write_byte(8'h02, 1'b0);
    i2c_rstart();
    write_byte(8'h91, 1'b0);
    read_byte(8'hA5, 1'b1);
    probe(P_OE, 0); probe(P_BUSY, 0);
    i2c_stop();
    probe(P_NTX, 1);
    gap();

    // Three-byte read: ACK, ACK, NACK
    probe(P_MARK, 0);
    tx_seq.push_back(8'h11); tx_seq.push_back(8'h22); tx_seq.push_back(8'h33);
    i2c_start();
    write_byte(8'h91, 1'b0);
    read_byte(8'h11, 1'b0);
    read_byte(8'h22, 1'b0);
    read_byte(8'h33, 1'b1);
    i2c_stop();
    probe(P_NTX, 3); probe(P_BUSY, 0);
    gap();

    // Foreign address 0x92 followed by a data byte: never driven
    probe(P_MARK, 0);
    i2c_start();
    write_byte(8'h92, 1'b1);
    write_byte(8'h55, 1'b1);
    probe(P_BUSY, 0);
    i2c_stop();
    probe(P_NOE, 0); probe(P_NCTRL, 0);
    gap();

    // Control byte then two DAC bytes
    probe(P_MARK, 0);
    i2c_start();
    write_byte(8'h90, 1'b0);
    exp_ctrl.push_back(8'h40);
    write_byte(8'h40, 1'b0);
    exp_dac.push_back(8'h80);
    write_byte(8'h80, 1'b0);
    exp_dac.push_back(8'h7F);
    write_byte(8'h7F, 1'b0);
    i2c_stop();
    probe(P_NDAC, 2); probe(P_NCTRL, 1); probe(P_CTRL, 8'h40); probe(P_DAC, 8'h7F);
    gap();

    // Reset while the target drives a 0 data bit
    tx_seq.push_back(8'h0F);
    i2c_start();
    write_byte(8'h91, 1'b0);
    probe(P_OE, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    probe(P_OE, 0);
    repeat (4) @(posedge clk);
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (4) @(posedge clk);
    probe(P_BUSY, 0); probe(P_CTRL, 0); probe(P_DAC, 0);
    rst_n = 1'b1;
    gap();
    probe(P_MARK, 0);
    i2c_start();
    write_byte(8'h90, 1'b0);
    probe(P_BUSY, 1);
    i2c_stop();
    probe(P_BUSY, 0); probe(P_NTX, 0);
    gap();

    probe(P_DRAIN, 0);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
